module_pipelined_adder: RTL and testbench
=========================================

// Module: module_pipelined_adder
//
// PURPOSE
// - Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake on both sides.
// - Splits a WIDTH-bit add into STAGES segments of SEG_W bits.
//   - Each segment is resolved in its own register stage; the carry ripples stage-to-stage.
// - Gives full throughput (one operation per cycle) at wide widths where a single ripple chain misses timing.
// - Sits between operand producers and downstream datapath/ALU consumers.
//
// PARAMETERS
// - WIDTH   16  operand/result bit width; must be a multiple of STAGES
// - STAGES  4   pipeline depth = number of segments (1..WIDTH); SEG_W = WIDTH/STAGES
//
// PORTS
// - clk_i      in   1      clock, all state on rising edge
// - rst_n_i    in   1      asynchronous active-low reset
// - valid_i    in   1      operand beat valid
// - ready_o    out  1      block can accept a beat this cycle
// - a_i        in   WIDTH  operand A (unsigned / two's complement)
// - b_i        in   WIDTH  operand B
// - carry_i    in   1      carry-in (add mode only)
// - sub_i      in   1      0: A+B+carry_i; 1: A-B (computed as A+~B+1; carry_i ignored)
// - valid_o    out  1      result beat valid
// - ready_i    in   1      downstream accepts result this cycle
// - sum_o      out  WIDTH  result
// - carry_o    out  1      carry-out of MSB; in sub mode 1 = no borrow (A >= B unsigned)
// - overflow_o out  1      signed overflow of the operation
//
// BEHAVIOUR
// - Reset (async assert, sync deassert by the system):
//   - All valid flags, data and carry registers clear to 0.
//   - valid_o=0, sum_o=0, carry_o=0, overflow_o=0.
//   - ready_o=1 after reset.
// - Transfers:
//   - An input beat transfers when valid_i & ready_o.
//   - An output beat transfers when valid_o & ready_i.
// - Global stall: adv = ~valid_o | ready_i.
//   - ready_o = adv (combinational from ready_i).
//   - All stage registers load only when adv=1.
//   - Bubbles advance while valid_o=0.
// - Latency: exactly STAGES cycles from input transfer to valid_o, when unstalled.
//   - Throughput is 1 beat/cycle.
//   - STAGES=1 reduces to a registered single-cycle adder.
// - Stage k (0..STAGES-1) adds segment k: [k*SEG_W +: SEG_W] of A and B' (B' = sub ? ~B : B).
//   - Carry-in of stage 0 is (sub ? 1 : carry_i).
//   - Carry-in of stage k>0 is the registered carry from stage k-1.
// - Operand skew: segment k of A/B' is delayed k register stages.
//   - Segments already summed are carried forward (output deskew) so all WIDTH bits of one beat leave together.
// - overflow_o = (A[MSB] == B'[MSB]) & (sum_o[MSB] != A[MSB]).
//   - Evaluated in the last stage using the delayed MSBs.
// - While stalled (valid_o & ~ready_i), sum_o/carry_o/overflow_o/valid_o hold stable; no beat is lost or duplicated.
// - Wrap-around: results are modulo 2^WIDTH; carry_o/overflow_o report the wrap.
// - Reset mid-operation: all in-flight beats are discarded; valid_o drops immediately on rst_n_i low.
// - sub_i and carry_i are sampled with the beat and travel with it.
//   - Mixed add/sub beats back-to-back are legal.
//
// STRUCTURE
// - Package pkg_adder:
//   - typedef seg_t sized by SEG_W, via parameterised function/localparam.
//   - localparam for SEG_W derivation and a parameter-check function (WIDTH % STAGES == 0).
//   - Elaboration error if the check fails.
// - Sub-module: module_ripple_carry_adder (RCAWIDE = SEG_W), one instance per segment, in a generate loop.
// - Pipeline registers, skew/deskew shift registers and valid chain live in this module.
//
// TESTING
// - WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, sub=0, carry_i=0 -> sum_o=0x0000, carry_o=1, overflow_o=0, valid_o exactly 4 cycles later.
// - sub=1, a=0x0005, b=0x0007 -> sum_o=0xFFFE, carry_o=0, overflow_o=0; a=0x0007, b=0x0005 -> 0x0002, carry_o=1.
// - a=0x7FFF, b=0x0001, add -> sum_o=0x8000, overflow_o=1; a=0x8000, b=0x0001, sub -> 0x7FFF, overflow_o=1.
// - Stream 20 random beats back-to-back, ready_i low for 3 cycles mid-stream.
//   - Required: ready_o low during the stall, outputs held, all 20 results in order and match the model.
// - Assert rst_n_i for 1 cycle with 3 beats in flight -> valid_o=0 at once, none of those beats emerge.
//   - Next beat has latency 4.
// - STAGES=1, WIDTH=8: 0x80+0x80, carry_i=1 -> sum_o=0x01, carry_o=1, overflow_o=1, latency 1.

Source files
------------

// File: rtl/module_pipelined_adder_pkg.sv
// Shared sizing helpers and types for the segmented pipelined adder.
package pkg_adder;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    localparam int DEF_SEG_W = seg_width(DEF_WIDTH, DEF_STAGES);

    typedef logic [DEF_SEG_W-1:0] def_seg_t;

endpackage

// File: rtl/module_ripple_carry_adder.sv
// Plain ripple-carry adder for one SEG_W-bit segment of the pipelined adder.
module module_ripple_carry_adder #(
    parameter int RCAWIDE = 4
) (
    input  logic [RCAWIDE-1:0] a_i,
    input  logic [RCAWIDE-1:0] b_i,
    input  logic               c_i,
    output logic [RCAWIDE-1:0] s_o,
    output logic               c_o
);

    logic [RCAWIDE:0] carry;

    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c_i;
        for (int i = 0; i < RCAWIDE; i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o = carry[RCAWIDE];

endmodule

// File: rtl/module_pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG_W segment resolved per stage,
// carry rippling stage-to-stage, with a single global stall from the output side.
module module_pipelined_adder
    import pkg_adder::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int SEG_W = seg_width(WIDTH, STAGES);

    typedef logic [SEG_W-1:0] seg_t;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("module_pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] bp_in;
    logic             cin_in;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    seg_t seg_a  [STAGES];
    seg_t seg_b  [STAGES];
    seg_t seg_s  [STAGES];
    logic seg_co [STAGES];
    logic [STAGES-1:0] seg_ci;

    // A stalled output freezes every stage; empty outputs let bubbles drain.
    assign adv        = ~valid_o | ready_i;
    assign ready_o    = adv;
    assign valid_o    = vld_q[STAGES-1];
    assign sum_o      = sum_q[STAGES-1];
    assign carry_o    = c_q[STAGES-1];
    assign overflow_o = ovf_q;

    // Stage k works on segment k of operands that have been skewed by k registers.
    always_comb begin
        bp_in     = sub_i ? ~b_i : b_i;
        cin_in    = sub_i ? 1'b1 : carry_i;
        seg_a[0]  = a_i[SEG_W-1:0];
        seg_b[0]  = bp_in[SEG_W-1:0];
        seg_ci[0] = cin_in;
        for (int k = 1; k < STAGES; k++) begin
            seg_a[k]  = a_q[k-1][k*SEG_W +: SEG_W];
            seg_b[k]  = b_q[k-1][k*SEG_W +: SEG_W];
            seg_ci[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        module_ripple_carry_adder #(
            .RCAWIDE (SEG_W)
        ) u_rca (
            .a_i (seg_a[k]),
            .b_i (seg_b[k]),
            .c_i (seg_ci[k]),
            .s_o (seg_s[k]),
            .c_o (seg_co[k])
        );
    end

    always_comb begin
        vld_d[0]              = valid_i;
        a_d[0]                = a_i;
        b_d[0]                = bp_in;
        sum_d[0]              = '0;
        sum_d[0][SEG_W-1:0]   = seg_s[0];
        c_d[0]                = seg_co[0];
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k]                     = vld_q[k-1];
            a_d[k]                       = a_q[k-1];
            b_d[k]                       = b_q[k-1];
            sum_d[k]                     = sum_q[k-1];
            sum_d[k][k*SEG_W +: SEG_W]   = seg_s[k];
            c_d[k]                       = seg_co[k];
        end
        // The last segment holds the operand MSBs, so overflow is decided there.
        ovf_d = (seg_a[STAGES-1][SEG_W-1] == seg_b[STAGES-1][SEG_W-1]) &&
                (sum_d[STAGES-1][WIDTH-1] != seg_a[STAGES-1][SEG_W-1]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_module_pipelined_adder.sv
// Scoreboard bench for the pipelined adder: 16-bit/4-stage and 8-bit/1-stage instances.
module tb_module_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v0_i, r0_o, c0_i, s0_i, v0_o, r0_i, co0, ov0;
    logic [15:0] a0, b0, sum0;

    logic        v1_i, r1_o, c1_i, s1_i, v1_o, r1_i, co1, ov1;
    logic [7:0]  a1, b1, sum1;

    module_pipelined_adder #(.WIDTH(16), .STAGES(4)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(v0_i), .ready_o(r0_o),
        .a_i(a0), .b_i(b0), .carry_i(c0_i), .sub_i(s0_i),
        .valid_o(v0_o), .ready_i(r0_i), .sum_o(sum0), .carry_o(co0), .overflow_o(ov0)
    );

    module_pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(v1_i), .ready_o(r1_o),
        .a_i(a1), .b_i(b1), .carry_i(c1_i), .sub_i(s1_i),
        .valid_o(v1_o), .ready_i(r1_i), .sum_o(sum1), .carry_o(co1), .overflow_o(ov1)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0m, e1m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // Reference: {overflow, carry, sum} straight from the arithmetic definition.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] bp;
        logic [16:0] r;
        logic        ovf;
        bp  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bp} + {16'd0, (sub ? 1'b1 : cin)};
        ovf = (a[15] == bp[15]) && (r[15] != a[15]);
        return {ovf, r};
    endfunction

    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] es, input logic ec,
                         input logic eo, input bit lat);
        int   w;
        exp_t e;
        a0 = a; b0 = b; c0_i = cin; s0_i = sub; v0_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!r0_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!r0_o) begin
            chk("dut0_accept_timeout", {31'd0, r0_o}, 32'd1);
        end else begin
            e.s = es; e.c = ec; e.o = eo; e.cyc = cyc; e.lat = lat;
            q0.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [7:0] es, input logic ec,
                         input logic eo);
        int   w;
        exp_t e;
        a1 = a; b1 = b; c1_i = cin; s1_i = sub; v1_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!r1_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!r1_o) begin
            chk("dut1_accept_timeout", {31'd0, r1_o}, 32'd1);
        end else begin
            e.s = {8'd0, es}; e.c = ec; e.o = eo; e.cyc = cyc; e.lat = 1'b1;
            q1.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_pending_beats", q0.size() + q1.size(), 0);
    endtask

    // Monitor for the 4-stage instance, including hold checks while stalled.
    logic [17:0] held0;
    bit          held0_v = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v0_o && r0_i) begin
                if (q0.size() == 0) begin
                    chk("dut0_unexpected_beat", {31'd0, v0_o}, 32'd0);
                end else begin
                    e0m = q0.pop_front();
                    chk("dut0_sum", {16'd0, sum0}, {16'd0, e0m.s});
                    chk("dut0_carry", {31'd0, co0}, {31'd0, e0m.c});
                    chk("dut0_overflow", {31'd0, ov0}, {31'd0, e0m.o});
                    if (e0m.lat) chk("dut0_latency", cyc - e0m.cyc, 4);
                end
            end
            if (v0_o && !r0_i) begin
                chk("dut0_ready_o_in_stall", {31'd0, r0_o}, 32'd0);
                if (held0_v) chk("dut0_hold_in_stall", {14'd0, ov0, co0, sum0}, {14'd0, held0});
                held0   = {ov0, co0, sum0};
                held0_v = 1'b1;
            end else begin
                held0_v = 1'b0;
            end
        end else begin
            held0_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && v1_o && r1_i) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_beat", {31'd0, v1_o}, 32'd0);
            end else begin
                e1m = q1.pop_front();
                chk("dut1_sum", {24'd0, sum1}, {16'd0, e1m.s});
                chk("dut1_carry", {31'd0, co1}, {31'd0, e1m.c});
                chk("dut1_overflow", {31'd0, ov1}, {31'd0, e1m.o});
                chk("dut1_latency", cyc - e1m.cyc, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] m;

        rst_n = 1'b0;
        v0_i = 1'b0; a0 = '0; b0 = '0; c0_i = 1'b0; s0_i = 1'b0; r0_i = 1'b0;
        v1_i = 1'b0; a1 = '0; b1 = '0; c1_i = 1'b0; s1_i = 1'b0; r1_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", {31'd0, v0_o}, 32'd0);
        chk("rst_sum_o", {16'd0, sum0}, 32'd0);
        chk("rst_carry_o", {31'd0, co0}, 32'd0);
        chk("rst_overflow_o", {31'd0, ov0}, 32'd0);
        chk("rst_ready_o", {31'd0, r0_o}, 32'd1);
        chk("rst_dut1_valid_o", {31'd0, v1_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r0_i = 1'b1;
        r1_i = 1'b1;
        @(posedge clk); #1;

        // Directed beats, back-to-back, hand-computed results.
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send0(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send0(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b1);
        send0(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send0(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        v0_i = 1'b0;
        wait_drain();

        // 20-beat stream with a 3-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                    m  = model16(ra, rb, rc, rs);
                    send0(ra, rb, rc, rs, m[15:0], m[16], m[17], 1'b0);
                end
                v0_i = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1 r0_i = 1'b0;
                repeat (3) @(posedge clk);
                #1 r0_i = 1'b1;
            end
        join
        wait_drain();

        // Reset with three beats in flight: none of them may ever emerge.
        send0(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);
        send0(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0, 1'b0);
        send0(16'h0A0A, 16'h0101, 1'b0, 1'b0, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        v0_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_valid_o", {31'd0, v0_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valid_o", {31'd0, v0_o}, 32'd0);
        chk("reset_clears_sum_o", {16'd0, sum0}, 32'd0);
        q0.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_o_after_reset", {31'd0, r0_o}, 32'd1);
        send0(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        v0_i = 1'b0;
        wait_drain();
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_beats_after_reset", {31'd0, v0_o}, 32'd0);

        // Single-stage 8-bit instance.
        send1(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        send1(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send1(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        v1_i = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
